// File: rtl/tpu_control_unit_if.sv
// Host instruction channel for tpu_control_unit.
//
// Carries one 64-bit instruction word per accepted transfer. A word is taken
// on every rising clock edge where instr_valid_in and instr_ready_out are both high.
//
// Signals:
//   instr_in         host instruction word
//   instr_valid_in   instr_in is valid
//   instr_ready_out  sequencer can accept a word (instruction FIFO not full)
//
// Modports:
//   master  host side: drives the word and valid, observes ready
//   slave   sequencer side: observes the word and valid, drives ready
interface tpu_control_unit_if;
  logic [63:0] instr_in;
  logic        instr_valid_in;
  logic        instr_ready_out;

  modport master (
    output instr_in,
    output instr_valid_in,
    input  instr_ready_out
  );

  modport slave (
    input  instr_in,
    input  instr_valid_in,
    output instr_ready_out
  );
endinterface

// File: rtl/tpu_control_unit.sv
// TPU instruction sequencer.
//
// Buffers 64-bit host instructions in a FIFO, fetches them one at a time,
// decodes them and drives the TPU control inputs. Launch pulses are high for
// exactly the ISSUE cycle of an instruction. Held outputs keep their value
// until a later instruction overwrites them. Each instruction can hold the
// sequencer for a programmable number of WAIT cycles.
//
// Instruction word:
//   [63:60] opcode: 0 NOP, 1 LOAD, 2 SETPATH, 3 SETREG, 4 HALT, 5..15 NOP
//   [15:0]  wait count (opcodes other than HALT)
//   LOAD    [59] transpose, [58:50] ptr, [49:34] addr, [33:26] rows, [25:18] cols
//   SETPATH [59:56] pathway, [55] systolic switch request
//   SETREG  [59:58] select (0 lr, 1 leak, 2 inv_batch, 3 none), [49:34] value
//
// Parameters:
//   FIFO_DEPTH  instruction FIFO entries (power of two, >= 2)
//
// Ports:
//   clk, rst                      clock; asynchronous active-high reset
//   host                          instruction channel (slave modport)
//   resume_in                     leaves HALT (ignored in other states)
//   ub_rd_start_in                one-cycle unified-buffer read launch
//   ub_rd_transpose               held read transpose flag
//   ub_ptr_select                 held pointer select
//   ub_rd_addr_in                 held read address
//   ub_rd_row_size/col_size       held sizes (8-bit fields, zero-extended)
//   learning_rate_in              held scalar register
//   vpu_leak_factor_in            held scalar register
//   inv_batch_size_times_two_in   held scalar register
//   vpu_data_pathway              held VPU pathway select
//   sys_switch_in                 one-cycle systolic weight-switch pulse
//   busy_out                      any state other than IDLE and HALT
//   halted_out                    in HALT
//
// Optional feature (macro TPU_CTRL_STATS_EN):
//   retired_count_out             ISSUE cycles seen (HALT included), wraps
//   stall_count_out               cycles with valid high and ready low
module tpu_control_unit #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  tpu_control_unit_if.slave   host,
  input  logic                resume_in,
  output logic                ub_rd_start_in,
  output logic                ub_rd_transpose,
  output logic [8:0]          ub_ptr_select,
  output logic [15:0]         ub_rd_addr_in,
  output logic [15:0]         ub_rd_row_size,
  output logic [15:0]         ub_rd_col_size,
  output logic [15:0]         learning_rate_in,
  output logic [15:0]         vpu_leak_factor_in,
  output logic [15:0]         inv_batch_size_times_two_in,
  output logic [3:0]          vpu_data_pathway,
  output logic                sys_switch_in,
  output logic                busy_out,
  output logic                halted_out
`ifdef TPU_CTRL_STATS_EN
  ,
  output logic [31:0]         retired_count_out,
  output logic [31:0]         stall_count_out
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [3:0] OpLoad    = 4'd1;
  localparam logic [3:0] OpSetPath = 4'd2;
  localparam logic [3:0] OpSetReg  = 4'd3;
  localparam logic [3:0] OpHalt    = 4'd4;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StWait,
    StHalt
  } state_e;

  state_e state_q, state_d;

  // ---------------------------------------------------------------------------
  // Instruction FIFO
  // ---------------------------------------------------------------------------
  logic [63:0]     fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic [63:0]     head;

  assign fifo_full            = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty           = (count_q == '0);
  // Ready depends only on occupancy, so a full FIFO refuses a push even in a
  // cycle where FETCH frees an entry.
  assign host.instr_ready_out = !fifo_full;
  assign push                 = host.instr_valid_in && !fifo_full;
  // FETCH is only entered with a non-empty FIFO, so the pop is always valid.
  assign pop                  = (state_q == StFetch);
  assign head                 = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= host.instr_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  logic [3:0]  ir_op_q, ir_op_d;
  logic [15:0] ir_wait_q, ir_wait_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  state_e      next_after_done;

  // Where to go once an instruction is finished (no wait left).
  assign next_after_done = fifo_empty ? StIdle : StFetch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ir_op_q    <= '0;
      ir_wait_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ir_op_q    <= ir_op_d;
      ir_wait_q  <= ir_wait_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_op_d    = ir_op_q;
    ir_wait_d  = ir_wait_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        ir_op_d   = head[63:60];
        ir_wait_d = head[15:0];
        state_d   = StIssue;
      end
      StIssue: begin
        if (ir_op_q == OpHalt) begin
          state_d = StHalt;
        end else if (ir_wait_q != '0) begin
          state_d    = StWait;
          wait_cnt_d = ir_wait_q - 16'd1;
        end else begin
          state_d = next_after_done;
        end
      end
      StWait: begin
        if (wait_cnt_q == '0) begin
          state_d = next_after_done;
        end else begin
          wait_cnt_d = wait_cnt_q - 16'd1;
        end
      end
      StHalt: begin
        if (resume_in) begin
          state_d = next_after_done;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Decode and TPU control registers
  // ---------------------------------------------------------------------------
  // The head word is decoded on the FETCH->ISSUE edge, so held outputs change
  // and pulses rise exactly as ISSUE begins, all straight from flops. Pulses
  // clear on the following edge because ISSUE never directly follows ISSUE.
  logic        start_q;
  logic        switch_q;
  logic        transpose_q;
  logic [8:0]  ptr_q;
  logic [15:0] addr_q;
  logic [7:0]  rows_q, cols_q;
  logic [15:0] lr_q, leak_q, inv_batch_q;
  logic [3:0]  path_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q     <= 1'b0;
      switch_q    <= 1'b0;
      transpose_q <= 1'b0;
      ptr_q       <= '0;
      addr_q      <= '0;
      rows_q      <= '0;
      cols_q      <= '0;
      lr_q        <= '0;
      leak_q      <= '0;
      inv_batch_q <= '0;
      path_q      <= '0;
    end else begin
      start_q  <= 1'b0;
      switch_q <= 1'b0;
      if (pop) begin
        case (head[63:60])
          OpLoad: begin
            start_q     <= 1'b1;
            transpose_q <= head[59];
            ptr_q       <= head[58:50];
            addr_q      <= head[49:34];
            rows_q      <= head[33:26];
            cols_q      <= head[25:18];
          end
          OpSetPath: begin
            path_q   <= head[59:56];
            switch_q <= head[55];
          end
          OpSetReg: begin
            case (head[59:58])
              2'd0:    lr_q        <= head[49:34];
              2'd1:    leak_q      <= head[49:34];
              2'd2:    inv_batch_q <= head[49:34];
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  // Bits [17:16] carry no field for any opcode.
  logic unused_head_bits;
  assign unused_head_bits = ^head[17:16];

  assign ub_rd_start_in              = start_q;
  assign sys_switch_in               = switch_q;
  assign ub_rd_transpose             = transpose_q;
  assign ub_ptr_select               = ptr_q;
  assign ub_rd_addr_in               = addr_q;
  assign ub_rd_row_size              = {8'h00, rows_q};
  assign ub_rd_col_size              = {8'h00, cols_q};
  assign learning_rate_in            = lr_q;
  assign vpu_leak_factor_in          = leak_q;
  assign inv_batch_size_times_two_in = inv_batch_q;
  assign vpu_data_pathway            = path_q;
  assign busy_out                    = (state_q != StIdle) && (state_q != StHalt);
  assign halted_out                  = (state_q == StHalt);

`ifdef TPU_CTRL_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics counters
  // ---------------------------------------------------------------------------
  logic [31:0] retired_q, stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (state_q == StIssue) begin
        retired_q <= retired_q + 32'd1;
      end
      if (host.instr_valid_in && fifo_full) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign retired_count_out = retired_q;
  assign stall_count_out   = stall_q;
`endif

endmodule
